// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash READ responder.
//   CMD_READ            : the only command byte the responder serves
//   state_t             : transaction state encoding
//   DEFAULT_ADDR_WIDTH  : default flash address width in bits
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ           = 8'h03;
  localparam int         DEFAULT_ADDR_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR0  = 3'd2,
    ADDR1  = 3'd3,
    ADDR2  = 3'd4,
    DATA   = 3'd5,
    IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags sclk edges.
// Ports:
//   clk, reset              : system clock, async active-high reset
//   spi_cs/spi_sclk/spi_mosi: raw SPI pins
//   sclk_rise / sclk_fall   : one-cycle pulses on synchronised sclk edges
//   cs_active               : synchronised chip select, asserted high
//   mosi_s                  : synchronised mosi, aligned with the sclk edges
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;

  // Pins reset to their idle levels (cs deselected, sclk high in mode 3)
  // so leaving reset never fabricates an edge or a selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q   <= '1;
      sclk_q <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b1;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign cs_active = ~cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-3 target emulating a serial NOR flash that answers READ (0x03).
// Bytes are fetched from a synchronous byte-wide memory port and streamed
// out MSB first in ascending address order.
// Ports:
//   clk, reset        : system clock, async active-high reset
//   spi_cs            : chip select, active low
//   spi_sclk          : SPI clock, idles high
//   spi_mosi          : master-out data, MSB first
//   spi_miso          : target-out data (1 when not streaming)
//   mem_addr          : byte address presented with mem_rd
//   mem_rd            : one-cycle read strobe
//   mem_rdata         : read data, valid one clk after mem_rd
//   busy              : synchronised chip select active
//   cmd_err           : one-cycle pulse when an unsupported command completes
//
// state  | meaning
// IDLE   | deselected, miso held 1
// CMD    | shifting in the command byte
// ADDR0  | shifting in address bits [23:16]
// ADDR1  | shifting in address bits [15:8]
// ADDR2  | shifting in address bits [7:0]
// DATA   | streaming memory bytes on miso, prefetching the next one
// IGNORE | unsupported command, wait for deselect
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  cmd_err
);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_active;
  logic mosi_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_active(cs_active),
    .mosi_s   (mosi_s)
  );

  state_t      state;
  state_t      next_state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [22:0] addr_sr;
  logic [7:0]  tx_sr;
  logic        load_pending;

  logic        byte_done;
  logic        rd_first;
  logic        rd_next;
  logic        err_now;
  logic [7:0]  rx_byte;
  logic [23:0] addr_full;

  // Values as they will stand once the bit arriving this cycle is included.
  assign rx_byte   = {rx_sr, mosi_s};
  assign addr_full = {addr_sr, mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Deselect overrides everything, which also discards any sclk edge that
  // shows up in the same synchronised cycle.
  always_comb begin
    next_state = state;
    byte_done  = cs_active && sclk_rise && (bit_cnt == 3'd7);
    rd_first   = 1'b0;
    rd_next    = 1'b0;
    err_now    = 1'b0;
    if (!cs_active) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CMD;
        CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_READ) begin
              next_state = ADDR0;
            end else begin
              next_state = IGNORE;
              err_now    = 1'b1;
            end
          end
        end
        ADDR0:   if (byte_done) next_state = ADDR1;
        ADDR1:   if (byte_done) next_state = ADDR2;
        ADDR2: begin
          if (byte_done) begin
            next_state = DATA;
            rd_first   = 1'b1;
          end
        end
        DATA:    rd_next = byte_done;
        IGNORE:  next_state = IGNORE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      rx_sr        <= '0;
      addr_sr      <= '0;
      tx_sr        <= '0;
      load_pending <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      cmd_err      <= 1'b0;
      spi_miso     <= 1'b1;
    end else begin
      mem_rd       <= rd_first | rd_next;
      load_pending <= rd_first | rd_next;
      cmd_err      <= err_now;

      if (rd_first) begin
        mem_addr <= addr_full[ADDR_WIDTH-1:0];
      end else if (rd_next) begin
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
      end

      if (!cs_active || state == IDLE) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (cs_active && sclk_rise) begin
        rx_sr <= rx_byte[6:0];
        if (state inside {ADDR0, ADDR1, ADDR2}) begin
          addr_sr <= addr_full[22:0];
        end
      end

      // A read answered after deselect is dropped rather than loaded.
      if (cs_active && load_pending) begin
        tx_sr <= mem_rdata;
      end else if (cs_active && state == DATA && sclk_fall) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end

      if (!cs_active || state != DATA) begin
        spi_miso <= 1'b1;
      end else if (sclk_fall) begin
        spi_miso <= tx_sr[7];
      end
    end
  end

  assign busy = cs_active;

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        spi_cs   = 1'b1;
  logic        spi_sclk = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_err;

  spi_flash_responder dut (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;
  int seen_err = 0;

  logic [7:0]  mem [int unsigned];
  logic [7:0]  exp_bytes[$];
  int          exp_counts[$];
  logic [23:0] exp_addr[$];
  logic [7:0]  mbuf[$];

  function automatic logic [7:0] mem_at(input logic [23:0] a);
    int unsigned k;
    k = 32'(a);
    if (mem.exists(k)) return mem[k];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory: data valid exactly one clk after the strobe, junk otherwise.
  initial forever begin
    @(negedge clk);
    if (mem_rd) mem_rdata = mem_at(mem_addr);
    else        mem_rdata = 8'($urandom);
  end

  // Read-strobe monitor.
  initial forever begin
    @(negedge clk);
    if (!reset && mem_rd) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_rd unexpected: got addr %h expected no read", mem_addr);
      end else begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmd_err) seen_err++;
  end

  // miso monitor: samples on rising sclk like the master, compares full bytes.
  initial forever begin
    logic [7:0] sh;
    int         nbits;
    int         n;
    logic [7:0] got[$];
    logic [7:0] e;
    @(negedge spi_cs);
    nbits = 0;
    sh = 8'h00;
    got.delete();
    forever begin
      @(posedge spi_sclk or posedge spi_cs);
      if (spi_cs) break;
      sh = {sh[6:0], spi_miso};
      nbits++;
      if (nbits % 8 == 0) got.push_back(sh);
    end
    if (exp_counts.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL miso_txn: got unexpected transaction expected none");
    end else begin
      n = exp_counts.pop_front();
      chk("miso_nbytes", 32'(got.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
        e = exp_bytes.pop_front();
        if (i < got.size()) chk("miso_byte", 32'(got[i]), 32'(e));
      end
    end
  end

  task automatic set_hdr(input logic [7:0] c, input logic [23:0] a, input int pad);
    mbuf.delete();
    mbuf.push_back(c);
    mbuf.push_back(a[23:16]);
    mbuf.push_back(a[15:8]);
    mbuf.push_back(a[7:0]);
    repeat (pad) mbuf.push_back(8'($urandom));
  endtask

  task automatic push_blank(input int nfull);
    exp_counts.push_back(nfull);
    repeat (nfull) exp_bytes.push_back(8'hFF);
  endtask

  // Reference: header bytes read back as FF, then n bytes of memory from a
  // upward (mod 2^24); n+1 reads including the prefetch after the last byte.
  task automatic push_read(input logic [23:0] a, input int n);
    exp_counts.push_back(4 + n);
    repeat (4) exp_bytes.push_back(8'hFF);
    for (int i = 0; i < n; i++) exp_bytes.push_back(mem_at(a + 24'(i)));
    for (int i = 0; i <= n; i++) exp_addr.push_back(a + 24'(i));
  endtask

  task automatic spi_xfer(input int nbits, input int half, input int rst_bit);
    logic [7:0] b;
    spi_cs = 1'b0;
    wait_clk(half);
    for (int i = 0; i < nbits; i++) begin
      b = mbuf[i / 8];
      spi_sclk = 1'b0;
      spi_mosi = b[7 - (i % 8)];
      if (i == rst_bit) begin
        wait_clk(2);
        reset = 1'b1;
        #1;
        chk("rst_miso", 32'(spi_miso), 32'd1);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        wait_clk(2);
        reset = 1'b0;
        spi_cs = 1'b1;
        wait_clk(1);
        spi_sclk = 1'b1;
        wait_clk(8);
        return;
      end
      wait_clk(half);
      spi_sclk = 1'b1;
      wait_clk(half);
    end
    chk("busy_sel", 32'(busy), 32'd1);
    spi_cs = 1'b1;
    wait_clk(6);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("miso_idle", 32'(spi_miso), 32'd1);
    wait_clk(2);
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input int half);
    set_hdr(CMD_READ, a, n);
    push_read(a, n);
    spi_xfer((4 + n) * 8, half, -1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  c;
    logic [23:0] a;
    int          kind;
    int          half;
    int          nb;

    mem[32'h100000] = 8'h34;
    mem[32'h100001] = 8'h12;

    wait_clk(3);
    chk("reset_miso", 32'(spi_miso), 32'd1);
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_err", 32'(cmd_err), 32'd0);
    reset = 1'b0;
    wait_clk(4);

    do_read(24'h100000, 2, 5);
    do_read(24'hFFFFFE, 4, 5);

    set_hdr(8'h9F, 24'($urandom), 0);
    push_blank(4);
    exp_err++;
    spi_xfer(32, 5, -1);

    set_hdr(CMD_READ, 24'h000010, 0);
    push_blank(2);
    spi_xfer(20, 5, -1);
    do_read(24'h000010, 1, 5);

    set_hdr(CMD_READ, 24'h000000, 2);
    exp_counts.push_back(5);
    repeat (4) exp_bytes.push_back(8'hFF);
    exp_bytes.push_back(mem_at(24'h000000));
    exp_addr.push_back(24'h000000);
    exp_addr.push_back(24'h000001);
    spi_xfer(48, 5, 45);
    do_read(24'h000000, 2, 5);

    do_read(24'($urandom), 2, 4);

    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 3);
      half = $urandom_range(4, 7);
      case (kind)
        0, 1: begin
          if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
          else                           a = 24'($urandom);
          do_read(a, $urandom_range(1, 3), half);
        end
        2: begin
          c = 8'($urandom);
          if (c == CMD_READ) c = 8'hA5;
          nb = $urandom_range(8, 32);
          set_hdr(c, 24'($urandom), 0);
          push_blank(nb / 8);
          exp_err++;
          spi_xfer(nb, half, -1);
        end
        default: begin
          nb = $urandom_range(1, 31);
          set_hdr(CMD_READ, 24'($urandom), 0);
          push_blank(nb / 8);
          spi_xfer(nb, half, -1);
        end
      endcase
    end

    wait_clk(20);
    chk("cmd_err_count", 32'(seen_err), 32'(exp_err));
    chk("reads_outstanding", 32'(exp_addr.size()), 32'd0);
    chk("txns_outstanding", 32'(exp_counts.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
